ifu_axi_lite_mo: RTL
====================

Name: ifu_axi_lite_mo

Overview:
Parametrised instruction-fetch unit that issues AXI-lite reads and keeps up to MAX_OUT reads in flight, replacing the single-outstanding fetch FSM.
- Exposes the AXI-lite read channels (AR, R) as ports instead of embedding the memory model.
- Returns {pc, inst, err} in order through a response FIFO.
- On flush, responses to stale reads are discarded without ever retracting an AR or blocking R.

Parameters:
ADDR_W, 32, pc/araddr width
DATA_W, 32, instruction/rdata width
MAX_OUT, 4, max AR-accepted-but-R-not-received reads (live plus stale), power of 2, >=1
RESP_DEPTH, 4, response FIFO depth, power of 2, >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  redirect; kills all live requests and queued responses
req_pc_i  in  ADDR_W  fetch address
req_valid_i  in  1  fetch request valid
req_ready_o  out  1  fetch request accepted when valid&ready
resp_inst_o  out  DATA_W  fetched instruction
resp_pc_o  out  ADDR_W  pc of resp_inst_o
resp_err_o  out  1  rresp != OKAY
resp_valid_o  out  1  response valid
resp_ready_i  in  1  consumer ready
araddr_o  out  ADDR_W  AXI read address
arvalid_o  out  1  AXI read address valid
arready_i  in  1  AXI read address ready
rdata_i  in  DATA_W  AXI read data
rresp_i  in  2  AXI read response
rvalid_i  in  1  AXI read data valid
rready_o  out  1  AXI read data ready

Behaviour:
- Reset (rst_i=0, async): all counters 0, FIFOs empty, AR register empty. Outputs: arvalid_o=0, araddr_o=0, resp_valid_o=0, resp_inst_o=0, resp_pc_o=0, resp_err_o=0, req_ready_o=0, rready_o=1.
- Counters and queues:
  - live = reads issued since the last flush and not yet answered; each has its pc stored in pc queue (depth MAX_OUT).
  - drop_cnt = stale reads; width clog2(MAX_OUT+1).
  - fifo_cnt = response FIFO occupancy.
- req_ready_o = !flush_i && (!arvalid_o || arready_i) && (live+drop_cnt < MAX_OUT) && (live+fifo_cnt < RESP_DEPTH).
  - The last term reserves a FIFO slot per live read, so rready_o is tied to 1 and R is never back-pressured.
- Accept (req_valid_i&&req_ready_o) in cycle N:
  - araddr_o<=req_pc_i, arvalid_o<=1 in N+1.
  - pc pushed to pc queue; live incremented.
  - A read counts as in flight from acceptance (including while AR is pending).
- AR register: arvalid_o/araddr_o stay stable until arready_i. This holds across flush_i, so a pending AR completes and becomes stale. arvalid_o drops the cycle after the handshake unless a new request is accepted in the same cycle (back-to-back issue).
- R handshake (rvalid_i), cycle M:
  - If drop_cnt>0: drop_cnt--, beat discarded.
  - Else: pop pc queue, push {pc, rdata_i, rresp_i!=0} to the FIFO; resp_valid_o=1 from M+1.
  - A response never bypasses the FIFO, so minimum request-to-response latency is 3 cycles with a 0-wait slave.
- Response output: FIFO head drives resp_*_o; pop on resp_valid_o&&resp_ready_i. Push and pop in the same cycle leaves occupancy unchanged. Outputs are order-preserving, in pc-queue order.
- flush_i in cycle F, effective at the next edge:
  - drop_cnt <= drop_cnt + live − (R beat in F ? 1 : 0). The beat in F is itself discarded.
  - live<=0, pc queue cleared, response FIFO cleared; resp_valid_o=0 from F+1.
  - req_ready_o=0 in F; new requests are accepted from F+1 even while drop_cnt>0.
  - Flush while resp_valid_o&&resp_ready_i: that pop is still a legal transfer, then the FIFO is cleared.
- Boundaries:
  - live+drop_cnt==MAX_OUT: no new accept until an R beat arrives.
  - FIFO full and consumer stalled: issue stops; rvalid_i is still absorbed because the slot was pre-reserved.
  - rvalid_i with live==0 and drop_cnt==0 is a protocol violation: assertion fires, state unchanged.
  - Pointers wrap modulo depth; depth 1 supported.

Decomposition:
- liang_pkg gains:
  - pc_t, inst_t (existing).
  - fetch_resp_t struct {pc_t pc; inst_t inst; logic err;}.
  - axi_resp_e {OKAY=2'b00, EXOKAY, SLVERR, DECERR}.
- Sub-module sync_fifo #(type T, DEPTH) with push/pop/clear/full/empty/count, instantiated twice:
  - pc queue: T=pc_t, DEPTH=MAX_OUT.
  - response FIFO: T=fetch_resp_t, DEPTH=RESP_DEPTH.

Test Plan:
- Single fetch: pc 0x8000_0000, arready_i=1, R one cycle later with rdata 0x0000_0413, OKAY -> resp_valid_o 3 cycles after accept with pc 0x8000_0000, inst 0x0000_0413, err 0.
- Pipelined: 4 back-to-back pcs 0x0,0x4,0x8,0xC, slave latency 5, resp_ready_i=1 -> 4 ARs in 4 consecutive cycles; req_ready_o=0 while live=4; responses in order with matching pcs.
- Flush mid-flight: 3 live, one AR stalled (arready_i=0), flush_i pulse -> arvalid_o/araddr_o unchanged until arready_i; next 3 R beats dropped; new pc 0x100 returns as the only resp.
- Backpressure: resp_ready_i=0, RESP_DEPTH=4 -> exactly 4 reads issued then req_ready_o=0; all data held; resp_ready_i=1 drains 4 in order.
- Flush coincident with rvalid_i and with a resp pop -> that beat dropped, drop_cnt=live−1, FIFO empty next cycle.
- Reset asserted with 2 live reads and FIFO non-empty -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/liang_pkg.sv
// liang_pkg: shared fetch-path types for the instruction-fetch unit.
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
        logic  err;
    } fetch_resp_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of arbitrary type with synchronous clear; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter type T = logic [31:0],
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = 32'(count) == DEPTH;
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end

endmodule

// File: rtl/ifu_axi_lite_mo.sv
// ifu_axi_lite_mo: multi-outstanding AXI-lite instruction fetch; in-order responses,
// stale reads after a flush are counted and their R beats silently dropped.
module ifu_axi_lite_mo
    import liang_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUT    = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] req_pc_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [DATA_W-1:0] resp_inst_o,
    output logic [ADDR_W-1:0] resp_pc_o,
    output logic              resp_err_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o
);
    localparam int LW = $clog2(MAX_OUT + 1);
    localparam int FW = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic              err;
    } resp_t;

    logic [LW-1:0]     live, drop_cnt;
    logic [FW-1:0]     fifo_cnt;
    logic [ADDR_W-1:0] pc_head;
    logic              accept, beat, keep, rsp_pop;
    logic              pcq_full, pcq_empty, rsp_full, rsp_empty;
    resp_t             rsp_in, rsp_head;

    // Counting live reads against the FIFO reserves a slot per read, so R never stalls.
    assign req_ready_o = rst_i && !flush_i && (!arvalid_o || arready_i)
                      && (32'(live) + 32'(drop_cnt) < 32'(MAX_OUT))
                      && (32'(live) + 32'(fifo_cnt) < 32'(RESP_DEPTH));
    assign accept  = req_valid_i && req_ready_o;
    assign beat    = rvalid_i && !(pcq_empty && drop_cnt == '0);
    assign keep    = beat && drop_cnt == '0 && !flush_i;
    assign rsp_pop = !rsp_empty && resp_ready_i;
    assign rsp_in  = '{pc: pc_head, inst: rdata_i, err: rresp_i != OKAY};
    assign rready_o     = 1'b1;
    assign resp_valid_o = !rsp_empty;
    assign resp_pc_o    = rsp_head.pc;
    assign resp_inst_o  = rsp_head.inst;
    assign resp_err_o   = rsp_head.err;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            arvalid_o <= 1'b0;
            araddr_o  <= '0;
        end else if (accept) begin
            arvalid_o <= 1'b1;
            araddr_o  <= req_pc_i;
        end else if (arready_i) begin
            arvalid_o <= 1'b0;
        end

    // Every beat during a flush consumes one read, whether it was already stale or still live.
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) drop_cnt <= '0;
        else if (flush_i) drop_cnt <= drop_cnt + live - LW'(beat);
        else if (beat && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;

    always_ff @(posedge clk_i)
        if (rst_i) begin
            assert (!(rvalid_i && pcq_empty && drop_cnt == '0));
            assert (!(accept && pcq_full));
            assert (!(keep && rsp_full && !rsp_pop));
        end

    sync_fifo #(.T(logic [ADDR_W-1:0]), .DEPTH(MAX_OUT)) u_pcq (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (flush_i),
        .push  (accept),
        .din   (req_pc_i),
        .pop   (keep),
        .dout  (pc_head),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (live)
    );

    sync_fifo #(.T(resp_t), .DEPTH(RESP_DEPTH)) u_rsp (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (flush_i),
        .push  (keep),
        .din   (rsp_in),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (fifo_cnt)
    );

endmodule
